// File: rtl/center_mat_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// center_mat_stream: buffers a SIZE_A x SIZE_B frame, computes each row mean,
// then replays the frame with the row mean subtracted (saturated).  Rev 1.0
// ---------------------------------------------------------------------------
module center_mat_stream #(
  parameter  int SIZE_A = 8,
  parameter  int SIZE_B = 8,
  parameter  int DATA_W = 32,
  localparam int ROW_W  = (SIZE_A > 1) ? $clog2(SIZE_A) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_mean,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last
);
  localparam int N      = SIZE_A * SIZE_B;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W  = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic signed [63:0]       DIVISOR   = 64'(SIZE_B);
  localparam logic [ADDR_W-1:0]        ADDR_LAST = ADDR_W'(N - 1);
  localparam logic [COL_W-1:0]         COL_LAST  = COL_W'(SIZE_B - 1);
  localparam logic [ROW_W-1:0]         ROW_LAST  = ROW_W'(SIZE_A - 1);
  localparam logic signed [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_MEAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [DATA_W-1:0]        out_mean_q, out_mean_d;
  logic [ROW_W-1:0]         out_row_q, out_row_d;
  logic signed [63:0]       sum_q   [SIZE_A];
  logic signed [63:0]       sum_d   [SIZE_A];
  logic signed [DATA_W-1:0] mean_q  [SIZE_A];
  logic signed [DATA_W-1:0] mean_d  [SIZE_A];
  logic signed [DATA_W-1:0] frame_q [N];
  logic signed [DATA_W-1:0] frame_d [N];
  logic signed [DATA_W:0]   diff;
  logic [DATA_W-1:0]        centred;
  logic                     load;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_mean_d  = out_mean_q;
    out_row_d   = out_row_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    frame_d     = frame_q;
    load        = 1'b0;
    in_ready    = (state_q == ST_LOAD);

    // One extra bit of headroom so the subtraction itself cannot wrap.
    diff = {frame_q[addr_q][DATA_W-1], frame_q[addr_q]}
         - {mean_q[row_q][DATA_W-1], mean_q[row_q]};
    if (diff[DATA_W] != diff[DATA_W-1]) begin
      centred = diff[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      centred = diff[DATA_W-1:0];
    end

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          frame_d[addr_q] = in_data;
          sum_d[row_q]    = sum_q[row_q] + {{(64-DATA_W){in_data[DATA_W-1]}}, in_data};
          addr_d          = addr_q + ADDR_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (addr_q == ADDR_LAST) begin
            state_d = ST_MEAN;
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      ST_MEAN: begin
        mean_d[row_q] = DATA_W'(sum_q[row_q] / DIVISOR);
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_DRAIN: begin
        // Output register refills whenever it is empty or being consumed.
        load = !done_q && (!out_valid_q || out_ready);
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = centred;
          out_mean_d  = mean_q[row_q];
          out_row_d   = row_q;
          out_last_d  = (addr_q == ADDR_LAST);
          addr_d      = addr_q + ADDR_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (addr_q == ADDR_LAST) begin
            done_d = 1'b1;
            addr_d = '0;
            row_d  = '0;
            col_d  = '0;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = ST_LOAD;
          addr_d      = '0;
          row_d       = '0;
          col_d       = '0;
          done_d      = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          sum_d       = '{default: '0};
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_mean_q  <= '0;
      out_row_q   <= '0;
      sum_q       <= '{default: '0};
      mean_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_mean_q  <= out_mean_d;
      out_row_q   <= out_row_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mean  = out_mean_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_center_mat_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_center_mat_stream: directed + random frames against a row-mean model.
// ---------------------------------------------------------------------------
module tb_center_mat_stream;
  localparam int SA = 2;
  localparam int SB = 4;
  localparam int W  = 32;
  localparam int NE = SA * SB;
  typedef longint frame_t [NE];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] out_mean;
  logic [0:0]   out_row;
  logic         out_last;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  center_mat_stream #(.SIZE_A(SA), .SIZE_B(SB), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mean (out_mean),
    .out_row  (out_row),
    .out_last (out_last)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sh7FFFFFFF) return 64'sh7FFFFFFF;
    if (v < -64'sh80000000) return -64'sh80000000;
    return v;
  endfunction

  task automatic send_frame(input frame_t f);
    int k = 0;
    int guard = 0;
    while (k < NE && guard < 100) begin
      in_valid = 1'b1;
      in_data  = W'(f[k]);
      if (in_ready) k++;
      tick();
      guard++;
    end
    check("send_count", k, NE);
    in_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: toggle each cycle, 2: random. Stops after 'take' outputs.
  task automatic recv_frame(input frame_t f, input int mode, input int take,
                            input bit keep_valid);
    longint       m [SA];
    longint       e [NE];
    int           got = 0;
    int           cyc = 0;
    bit           seen = 1'b0;
    bit           stall = 1'b0;
    logic [W-1:0] hd = '0;
    logic [W-1:0] hm = '0;
    logic [0:0]   hr = '0;
    logic         hl = 1'b0;
    for (int r = 0; r < SA; r++) begin
      longint s = 0;
      for (int c = 0; c < SB; c++) s += f[r*SB+c];
      m[r] = s / SB;
    end
    for (int k = 0; k < NE; k++) e[k] = sat32(f[k] - m[k/SB]);

    while (got < take && cyc < 200) begin
      if (keep_valid) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", $signed(out_data), $signed(hd));
        check("stall_mean", $signed(out_mean), $signed(hm));
        check("stall_row", out_row, hr);
        check("stall_last", out_last, hl);
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", cyc, SA + 1);
        end
        check("in_ready_drain", in_ready, 0);
        if (out_ready) begin
          check("data", $signed(out_data), e[got]);
          check("mean", $signed(out_mean), m[got/SB]);
          check("row", out_row, got / SB);
          check("last", out_last, (got == NE - 1));
          got++;
        end
      end
      stall = out_valid && !out_ready;
      hd = out_data;
      hm = out_mean;
      hr = out_row;
      hl = out_last;
      tick();
      cyc++;
    end
    check("recv_count", got, take);
    out_ready = 1'b0;
    if (take == NE) begin
      check("idle_valid", out_valid, 0);
      check("ready_after_last", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mean", out_mean, 0);
    check("rst_out_row", out_row, 0);
    rst = 1'b0;
    tick();

    // Basic frame
    f = '{1, 2, 3, 6, 10, 10, 10, 10};
    send_frame(f);
    recv_frame(f, 0, NE, 1'b0);

    // Truncation toward zero
    f = '{-7, 0, 0, 0, -1, -2, 0, 0};
    send_frame(f);
    recv_frame(f, 0, NE, 1'b0);

    // Saturation
    f = '{64'sh7FFFFFFF, 64'sh7FFFFFFF, 64'sh7FFFFFFF, -64'sh80000000, 0, 0, 0, 0};
    send_frame(f);
    recv_frame(f, 0, NE, 1'b0);

    // Backpressure toggling, in_valid held high during drain
    for (int k = 0; k < NE; k++) f[k] = int'($urandom_range(0, 2000)) - 1000;
    send_frame(f);
    recv_frame(f, 1, NE, 1'b1);
    in_valid = 1'b0;

    // Reset mid-drain after 3 outputs
    for (int k = 0; k < NE; k++) f[k] = longint'($signed($urandom));
    send_frame(f);
    recv_frame(f, 0, 3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    f = '{5, 5, 5, 5, 0, 0, 0, 4};
    send_frame(f);
    recv_frame(f, 0, NE, 1'b0);

    // Back-to-back frames with in_valid always high
    for (int k = 0; k < NE; k++) f[k] = int'($urandom_range(0, 200)) - 100;
    send_frame(f);
    recv_frame(f, 0, NE, 1'b1);
    for (int k = 0; k < NE; k++) f[k] = longint'($signed($urandom));
    send_frame(f);
    recv_frame(f, 0, NE, 1'b1);
    in_valid = 1'b0;

    // Random frames with assorted downstream behaviour
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NE; k++) begin
        if (t[0]) f[k] = longint'($signed($urandom));
        else      f[k] = int'($urandom_range(0, 200)) - 100;
      end
      send_frame(f);
      recv_frame(f, t % 3, NE, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
